clk_div_sched: RTL and testbench
================================

Name: clk_div_sched

Overview:
- Two-channel programmable clock-enable scheduler. Replaces free-running fixed divider counters with runtime-reconfigurable dividers.
- Channel A is the slow/display rate (1 Hz class); channel B is the fast/scan rate (kHz class).
- Each channel produces a one-cycle tick (clock enable) and a 50% square wave.
- A valid/ready config port retargets a divider glitch-free: the new value is applied only at that channel's period boundary.

Parameters:
- CNT_W, 26, width of counters and divide values
- DEF_DIV_A, 25_000_000, channel A reset divide value (half-period = DIV+1 cycles)
- DEF_DIV_B, 32, channel B reset divide value

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  global run enable; low freezes both channels
- cfg_valid  in  1  config request
- cfg_ready  out  1  scheduler can accept a config
- cfg_sel  in  1  target channel: 0 = A, 1 = B
- cfg_div  in  CNT_W  new divide value
- tick_a  out  1  one-cycle pulse at channel A terminal count
- tick_b  out  1  one-cycle pulse at channel B terminal count
- sq_a  out  1  channel A square wave
- sq_b  out  1  channel B square wave
- busy  out  1  a config is pending

Behaviour:
- Reset (rst=1 at posedge):
  - cnt_a = cnt_b = 0; div_a = DEF_DIV_A; div_b = DEF_DIV_B.
  - tick_a = tick_b = 0; sq_a = sq_b = 0; cfg_ready = 1; busy = 0.
  - Any pending config is discarded.
- Channel counting (en=1), per cycle:
  - If cnt == div: cnt <= 0, tick <= 1, sq <= ~sq.
  - Otherwise: cnt <= cnt+1, tick <= 0.
  - Tick is registered, so it is high the cycle after cnt == div.
  - Half-period of sq = div+1 cycles; tick period = div+1 cycles.
  - div = 0 gives tick high every cycle and sq toggling every cycle.
- en=0: counters and sq hold; ticks are forced 0 on the next cycle. Counting resumes from the held count when en returns to 1.
- Config FSM, states IDLE and PEND:
  - IDLE: cfg_ready=1, busy=0. On cfg_valid & cfg_ready, latch sel/div into a pending register and go to PEND.
  - PEND: cfg_ready=0, busy=1.
    - With en=1, apply at the selected channel's next terminal count: that channel's cnt <= 0 as normal and div <= pending value, effective from the following count. Return to IDLE the next cycle.
    - With en=0, apply on the next cycle: div <= pending, cnt <= 0, sq held. Return to IDLE.
  - The non-selected channel is never disturbed.
- Boundary rules:
  - Config accepted in the same cycle the selected channel hits terminal count: not applied at that boundary. It waits for the next boundary, which runs with the old div.
  - New div smaller than the current cnt: no effect until the boundary, so there is no wrap or overflow.
  - cfg_valid while busy: ignored (not accepted); the requester holds valid.
  - rst during PEND: pending dropped, defaults restored, FSM returns to IDLE.
  - Counter arithmetic is unsigned CNT_W bits; cnt never exceeds div.

Decomposition:
- Shared package holds:
  - CNT_W default
  - channel-select constants CH_A = 0, CH_B = 1
  - FSM state encoding IDLE = 0, PEND = 1
- Sub-module div_channel, instantiated twice: counter, tick, sq, and the load port (load, load_div, force_clr).
- The top level holds the config FSM and the pending register.

Test Plan:
All scenarios use CNT_W=8, DEF_DIV_A=4, DEF_DIV_B=1.
1. Reset release, en=1, run 20 cycles -> tick_a every 5 cycles, sq_a toggles every 5 cycles; tick_b every 2 cycles; first tick_a 5 cycles after counting starts.
2. Config sel=A, div=2 accepted mid-period (cnt_a=1) -> cfg_ready low and busy high until A's terminal count. The remaining old period completes (5-cycle tick spacing), then tick_a spacing is 3 cycles; channel B spacing is unchanged.
3. Config sel=B, div=3 accepted in the exact cycle cnt_b==div_b -> the next B period still uses 2 cycles, subsequent periods use 4; busy spans one extra boundary.
4. en=0 at cnt_a=2 for 10 cycles -> no ticks, sq_a and cnt_a frozen; after en=1, the next tick_a arrives 3 cycles later.
5. en=0, config sel=A, div=7 -> applied the next cycle, cnt_a=0, sq_a unchanged, cfg_ready high again; after en=1, tick_a every 8 cycles.
6. rst asserted while busy=1 -> the next cycle has cfg_ready=1, busy=0, div_a=4, div_b=1, all outputs 0; the pending config is never applied.

Source files
------------

// File: rtl/clk_div_sched_pkg.sv
// Shared constants and types for the two-channel clock-enable scheduler.
// Channel select encoding and config FSM states live here.
package clk_div_sched_pkg;

    localparam int unsigned CNT_W_DEF = 26;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/clk_div_sched_if.sv
// Valid/ready config port used to retarget one divider at a time.
// The master drives a request; the scheduler answers with cfg_ready.
interface clk_div_sched_if
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_sel;
    logic [CNT_W-1:0] cfg_div;

    modport master (
        output cfg_valid,
        output cfg_sel,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_sel,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_sched_div_channel.sv
// One divider channel: counter, registered tick and 50% square wave.
// A new divide value lands only at terminal count, or at once via force_clr.
module clk_div_sched_div_channel
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned DEF_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             force_clr_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic             term_o,
    output logic             tick_o,
    output logic             sq_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;

    assign term_o = (cnt_q == div_q);
    assign tick_o = tick_q;
    assign sq_o   = sq_q;

    always_comb begin
        cnt_d  = cnt_q;
        div_d  = div_q;
        tick_d = 1'b0;
        sq_d   = sq_q;
        if (force_clr_i) begin
            cnt_d = '0;
            div_d = load_div_i;
        end else if (en_i) begin
            if (term_o) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sq_d   = ~sq_q;
                // Retarget only on the boundary so the wave never glitches
                if (load_i) div_d = load_div_i;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            div_q  <= CNT_W'(DEF_DIV);
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            div_q  <= div_d;
            tick_q <= tick_d;
            sq_q   <= sq_d;
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Two-channel programmable clock-enable scheduler (A slow, B fast).
// Holds the config FSM and the pending request register.
module clk_div_sched
    import clk_div_sched_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter int unsigned DEF_DIV_A = 25_000_000,
    parameter int unsigned DEF_DIV_B = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    clk_div_sched_if.slave  cfg,
    output logic            tick_a,
    output logic            tick_b,
    output logic            sq_a,
    output logic            sq_b,
    output logic            busy
);

    cfg_state_e       state_q;
    logic             sel_q;
    logic [CNT_W-1:0] pdiv_q;
    logic             ready_q;
    logic             busy_q;

    logic term_a, term_b;
    logic sel_term, apply;
    logic pend_a, pend_b;

    assign pend_a   = (state_q == PEND) && (sel_q == CH_A);
    assign pend_b   = (state_q == PEND) && (sel_q == CH_B);
    assign sel_term = (sel_q == CH_B) ? term_b : term_a;
    assign apply    = (state_q == PEND) && (!en || sel_term);

    assign cfg.cfg_ready = ready_q;
    assign busy          = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= CH_A;
            pdiv_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (cfg.cfg_valid && ready_q) begin
                    sel_q   <= cfg.cfg_sel;
                    pdiv_q  <= cfg.cfg_div;
                    state_q <= PEND;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                end
                PEND: if (apply) begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    clk_div_sched_div_channel #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV_A)
    ) u_ch_a (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .load_i      (pend_a),
        .force_clr_i (pend_a && !en),
        .load_div_i  (pdiv_q),
        .term_o      (term_a),
        .tick_o      (tick_a),
        .sq_o        (sq_a)
    );

    clk_div_sched_div_channel #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV_B)
    ) u_ch_b (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en),
        .load_i      (pend_b),
        .force_clr_i (pend_b && !en),
        .load_div_i  (pdiv_q),
        .term_o      (term_b),
        .tick_o      (tick_b),
        .sq_o        (sq_b)
    );

endmodule

// File: tb/tb_clk_div_sched.sv
// Randomized bench for clk_div_sched against a per-channel arithmetic model.
// Directed phases hit boundary configs, frozen enable and reset while busy.
module tb_clk_div_sched;
    import clk_div_sched_pkg::*;

    localparam int W = 8;
    localparam int DA = 4;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic tick_a, tick_b, sq_a, sq_b, busy;

    clk_div_sched_if #(.CNT_W(W)) cfg_if ();

    clk_div_sched #(
        .CNT_W     (W),
        .DEF_DIV_A (DA),
        .DEF_DIV_B (DB)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cfg    (cfg_if),
        .tick_a (tick_a),
        .tick_b (tick_b),
        .sq_a   (sq_a),
        .sq_b   (sq_b),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: each channel is a phase position within a period of div+1
    int m_cnt [2];
    int m_div [2];
    bit m_sq  [2];
    bit m_tick[2];
    bit m_pend;
    bit m_psel;
    int m_pdiv;
    bit m_acc;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit applied;
        m_acc = 1'b0;
        if (rst) begin
            m_cnt  = '{0, 0};
            m_div  = '{DA, DB};
            m_sq   = '{0, 0};
            m_tick = '{0, 0};
            m_pend = 1'b0;
            return;
        end
        applied = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bit mine = m_pend && (int'(m_psel) == c);
            m_tick[c] = 1'b0;
            if (mine && !en) begin
                m_div[c] = m_pdiv;
                m_cnt[c] = 0;
                applied = 1'b1;
            end else if (en) begin
                if (m_cnt[c] == m_div[c]) begin
                    m_cnt[c]  = 0;
                    m_tick[c] = 1'b1;
                    m_sq[c]   = ~m_sq[c];
                    if (mine) begin
                        m_div[c] = m_pdiv;
                        applied = 1'b1;
                    end
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) % (1 << W);
                end
            end
        end
        if (applied) begin
            m_pend = 1'b0;
        end else if (!m_pend && cfg_if.cfg_valid) begin
            m_pend = 1'b1;
            m_psel = cfg_if.cfg_sel;
            m_pdiv = int'(cfg_if.cfg_div);
            m_acc  = 1'b1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("tick_a", tick_a, m_tick[0]);
        chk("tick_b", tick_b, m_tick[1]);
        chk("sq_a", sq_a, m_sq[0]);
        chk("sq_b", sq_b, m_sq[1]);
        chk("cfg_ready", cfg_if.cfg_ready, !m_pend);
        chk("busy", busy, m_pend);
    endtask

    task automatic req(bit sel, int div);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_sel   = sel;
        cfg_if.cfg_div   = W'(div);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int waitc;
        int first;
        rst = 1'b1;
        en  = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_sel   = 1'b0;
        cfg_if.cfg_div   = '0;
        m_pend = 1'b0;
        m_psel = 1'b0;
        m_pdiv = 0;
        do_reset();

        // Free run; first tick_a must arrive on the fifth counting edge
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (first == 0 && tick_a) first = i;
        end
        chk("first_tick_a", first, 5);

        // Retarget A mid-period
        waitc = 0;
        while (m_cnt[0] != 1 && waitc < 20) begin
            step();
            waitc++;
        end
        req(CH_A, 2);
        step();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Retarget B exactly on its terminal-count cycle
        waitc = 0;
        while (m_cnt[1] != m_div[1] && waitc < 20) begin
            step();
            waitc++;
        end
        chk("wait_b_term", waitc < 20, 1);
        req(CH_B, 3);
        step();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Freeze with en low, then resume
        waitc = 0;
        while (m_cnt[0] != 2 && waitc < 20) begin
            step();
            waitc++;
        end
        en = 1'b0;
        for (int i = 0; i < 10; i++) step();
        en = 1'b1;
        for (int i = 0; i < 10; i++) step();

        // Config while frozen applies on the next cycle
        en = 1'b0;
        req(CH_A, 7);
        step();
        cfg_if.cfg_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        en = 1'b1;
        for (int i = 0; i < 30; i++) step();

        // Reset while a config is pending drops it
        req(CH_B, 9);
        step();
        cfg_if.cfg_valid = 1'b0;
        chk("busy_before_rst", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ready_after_rst", cfg_if.cfg_ready, 1);
        for (int i = 0; i < 20; i++) step();

        // Randomized traffic, requester holds valid until accepted
        for (int i = 0; i < 3000; i++) begin
            en  = ($urandom_range(9) != 0);
            rst = ($urandom_range(199) == 0);
            if (!cfg_if.cfg_valid || m_acc) begin
                if ($urandom_range(4) == 0)
                    req(1'($urandom_range(1)), $urandom_range(9));
                else
                    cfg_if.cfg_valid = 1'b0;
            end
            step();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
